// File: rtl/tage_ctrl_pkg.sv
// Shared types for the TAGE trace replay controller: FSM states, the trace
// entry layout and the default statistics window length.
package tage_ctrl_pkg;

  localparam int DEFAULT_ADDRESS_SIZE = 32;
  localparam int DEFAULT_WINDOW       = 100000;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    LOAD    = 3'd2,
    PREDICT = 3'd3,
    UPDATE  = 3'd4,
    DONE    = 3'd5
  } ctrlState_e;

  typedef struct packed {
    logic                            outcome;
    logic [DEFAULT_ADDRESS_SIZE-1:0] pc;
  } traceEntry_t;

  // A retired branch counts as a hit when the prediction equals the outcome.
  function automatic logic predHit(input logic predTaken, input logic outcome);
    return ~(predTaken ^ outcome);
  endfunction

endpackage

// File: rtl/window_stat_counter.sv
// Per-window hit statistics for the trace replay controller; the last closed
// window's hit count is held until the next window closes.
module window_stat_counter #(
  parameter int WINDOW   = 100000,
  parameter int WINDOW_W = $clog2(WINDOW + 1)
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                Clear,
  input  logic                Retire,
  input  logic                Hit,
  input  logic                Last,
  output logic [WINDOW_W-1:0] WindowHits,
  output logic                WindowValid
);

  localparam logic [WINDOW_W-1:0] WIN_LAST = WINDOW_W'(WINDOW - 1);
  localparam logic [WINDOW_W-1:0] WIN_ONE  = WINDOW_W'(1);

  logic [WINDOW_W-1:0] winCnt_r;
  logic [WINDOW_W-1:0] winHits_r;
  logic [WINDOW_W-1:0] windowHits_r;
  logic                windowValid_r;
  logic [WINDOW_W-1:0] hitExt_s;
  logic                closeWin_s;

  assign hitExt_s   = {{(WINDOW_W-1){1'b0}}, Hit};
  // The final entry of a run closes a partial window so it is never lost.
  assign closeWin_s = Retire && ((winCnt_r == WIN_LAST) || Last);

  // Window counters, closed-window result and its one-cycle valid pulse.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      winCnt_r      <= '0;
      winHits_r     <= '0;
      windowHits_r  <= '0;
      windowValid_r <= 1'b0;
    end else if (Clear) begin
      winCnt_r      <= '0;
      winHits_r     <= '0;
      windowHits_r  <= '0;
      windowValid_r <= 1'b0;
    end else begin
      windowValid_r <= closeWin_s;
      if (closeWin_s) begin
        windowHits_r <= winHits_r + hitExt_s;
        winCnt_r     <= '0;
        winHits_r    <= '0;
      end else if (Retire) begin
        winCnt_r  <= winCnt_r + WIN_ONE;
        winHits_r <= winHits_r + hitExt_s;
      end
    end
  end

  assign WindowHits  = windowHits_r;
  assign WindowValid = windowValid_r;

endmodule

// File: rtl/trace_replay_ctrl.sv
// Replays the training trace into the TAGE predictor: fetch, predict, update and
// retire one branch at a time. Window statistics are built when TRACE_WINDOW_STATS_EN is defined.
module trace_replay_ctrl
  import tage_ctrl_pkg::*;
#(
  parameter int ADDRESS_SIZE           = DEFAULT_ADDRESS_SIZE,
  parameter int TRAINING_DATA_SIZE     = 3898078,
  // One spare code point so a full run's branch count never wraps.
  parameter int INSTRUCTION_INDEX_SIZE = $clog2(TRAINING_DATA_SIZE + 1),
  parameter int WINDOW                 = DEFAULT_WINDOW,
  parameter int WINDOW_W               = $clog2(WINDOW + 1)
) (
  input  logic                              Clk,
  input  logic                              Rst,
  input  logic                              Start,
  output logic [INSTRUCTION_INDEX_SIZE-1:0] TraceAddr,
  input  logic [ADDRESS_SIZE:0]             TraceData,
  output logic                              PredReq,
  output logic [ADDRESS_SIZE-1:0]           PredPC,
  input  logic                              PredValid,
  input  logic                              PredTaken,
  output logic                              UpdReq,
  output logic                              UpdTaken,
  input  logic                              UpdAck,
  output logic [INSTRUCTION_INDEX_SIZE-1:0] TotalBranches,
  output logic [INSTRUCTION_INDEX_SIZE-1:0] CorrectlyPredicted,
  output logic [WINDOW_W-1:0]               WindowHits,
  output logic                              WindowValid,
  output logic                              Busy,
  output logic                              Done
);

  localparam int IW = INSTRUCTION_INDEX_SIZE;
  localparam logic [IW-1:0] LAST_IDX = IW'(TRAINING_DATA_SIZE - 1);
  localparam logic [IW-1:0] ONE_IDX  = IW'(1);

  ctrlState_e              state_r, stateNext_s;
  logic [IW-1:0]           idx_r, total_r, correct_r;
  logic [ADDRESS_SIZE-1:0] pc_r;
  logic                    out_r, predTaken_r;
  logic                    predReq_r, updReq_r, busy_r, done_r;
  logic                    startRun_s, retire_s, lastEntry_s, match_s;

  assign startRun_s  = Start && ((state_r == IDLE) || (state_r == DONE));
  assign retire_s    = (state_r == UPDATE) && UpdAck;
  assign lastEntry_s = (idx_r == LAST_IDX);
  assign match_s     = predHit(predTaken_r, out_r);

  // State register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state_r <= IDLE;
    else      state_r <= stateNext_s;
  end

  // Next-state logic; handshakes arriving outside their state fall through unseen.
  always_comb begin
    stateNext_s = state_r;
    case (state_r)
      IDLE:    if (Start) stateNext_s = FETCH; else stateNext_s = IDLE;
      FETCH:   stateNext_s = LOAD;
      LOAD:    stateNext_s = PREDICT;
      PREDICT: if (PredValid) stateNext_s = UPDATE; else stateNext_s = PREDICT;
      UPDATE: begin
        if (UpdAck) stateNext_s = lastEntry_s ? DONE : FETCH;
        else        stateNext_s = UPDATE;
      end
      DONE:    if (Start) stateNext_s = FETCH; else stateNext_s = DONE;
      default: stateNext_s = IDLE;
    endcase
  end

  // Trace index, run totals, captured entry and prediction; outputs decoded from next state.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      idx_r       <= '0;
      total_r     <= '0;
      correct_r   <= '0;
      pc_r        <= '0;
      out_r       <= 1'b0;
      predTaken_r <= 1'b0;
      predReq_r   <= 1'b0;
      updReq_r    <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      if (startRun_s) begin
        idx_r     <= '0;
        total_r   <= '0;
        correct_r <= '0;
      end else if (retire_s) begin
        idx_r     <= idx_r + ONE_IDX;
        total_r   <= total_r + ONE_IDX;
        correct_r <= correct_r + {{(IW-1){1'b0}}, match_s};
      end
      if (state_r == LOAD) begin
        pc_r  <= TraceData[ADDRESS_SIZE-1:0];
        out_r <= TraceData[ADDRESS_SIZE];
      end
      if ((state_r == PREDICT) && PredValid) predTaken_r <= PredTaken;
      predReq_r <= (stateNext_s == PREDICT);
      updReq_r  <= (stateNext_s == UPDATE);
      busy_r    <= (stateNext_s != IDLE) && (stateNext_s != DONE);
      done_r    <= (stateNext_s == DONE);
    end
  end

  assign TraceAddr          = idx_r;
  assign PredReq            = predReq_r;
  assign PredPC             = pc_r;
  assign UpdReq             = updReq_r;
  assign UpdTaken           = out_r;
  assign TotalBranches      = total_r;
  assign CorrectlyPredicted = correct_r;
  assign Busy               = busy_r;
  assign Done               = done_r;

`ifdef TRACE_WINDOW_STATS_EN
  window_stat_counter #(
    .WINDOW   (WINDOW),
    .WINDOW_W (WINDOW_W)
  ) uWindowStat (
    .Clk         (Clk),
    .Rst         (Rst),
    .Clear       (startRun_s),
    .Retire      (retire_s),
    .Hit         (match_s),
    .Last        (lastEntry_s),
    .WindowHits  (WindowHits),
    .WindowValid (WindowValid)
  );
`else
  assign WindowHits  = '0;
  assign WindowValid = 1'b0;
`endif

endmodule

// File: tb/tb_trace_replay_ctrl.sv
// Directed bench for trace_replay_ctrl: an 8-entry run (instance A) and a
// 6-entry run (instance B), both with a 4-branch window and a 1-cycle trace ROM.
module tb_trace_replay_ctrl;

  localparam int AS  = 32;
  localparam int NA  = 8;
  localparam int NB  = 6;
  localparam int WIN = 4;
  localparam int IWA = $clog2(NA + 1);
  localparam int IWB = $clog2(NB + 1);
  localparam int WW  = $clog2(WIN + 1);

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  always #5 Clk = ~Clk;

  int cmpCount = 0;
  int errCount = 0;

  logic [AS:0] rom [0:7];
  logic [7:0]  outcomeBits = 8'b1011_0010;
  logic [7:0]  wrongMask   = 8'd0;
  int          predDelay   = 0;
  logic        updHold     = 1'b0;

  // Instance A signals
  logic           startA = 1'b0;
  logic [IWA-1:0] traceAddrA, totalA, correctA;
  logic [AS:0]    traceDataA;
  logic           predReqA, predValidA, predTakenA, updReqA, updTakenA, updAckA;
  logic [AS-1:0]  predPCA;
  logic [WW-1:0]  winHitsA;
  logic           winValidA, busyA, doneA;

  // Instance B signals
  logic           startB = 1'b0;
  logic [IWB-1:0] traceAddrB, totalB, correctB;
  logic [AS:0]    traceDataB;
  logic           predReqB, predValidB, predTakenB, updReqB, updTakenB, updAckB;
  logic [AS-1:0]  predPCB;
  logic [WW-1:0]  winHitsB;
  logic           winValidB, busyB, doneB;

  trace_replay_ctrl #(.ADDRESS_SIZE(AS), .TRAINING_DATA_SIZE(NA), .WINDOW(WIN)) dutA (
    .Clk(Clk), .Rst(Rst), .Start(startA), .TraceAddr(traceAddrA), .TraceData(traceDataA),
    .PredReq(predReqA), .PredPC(predPCA), .PredValid(predValidA), .PredTaken(predTakenA),
    .UpdReq(updReqA), .UpdTaken(updTakenA), .UpdAck(updAckA),
    .TotalBranches(totalA), .CorrectlyPredicted(correctA),
    .WindowHits(winHitsA), .WindowValid(winValidA), .Busy(busyA), .Done(doneA));

  trace_replay_ctrl #(.ADDRESS_SIZE(AS), .TRAINING_DATA_SIZE(NB), .WINDOW(WIN)) dutB (
    .Clk(Clk), .Rst(Rst), .Start(startB), .TraceAddr(traceAddrB), .TraceData(traceDataB),
    .PredReq(predReqB), .PredPC(predPCB), .PredValid(predValidB), .PredTaken(predTakenB),
    .UpdReq(updReqB), .UpdTaken(updTakenB), .UpdAck(updAckB),
    .TotalBranches(totalB), .CorrectlyPredicted(correctB),
    .WindowHits(winHitsB), .WindowValid(winValidB), .Busy(busyB), .Done(doneB));

  // Bench-side bookkeeping
  logic [IWA-1:0] brA = '0;
  logic [IWB-1:0] brB = '0;
  int retA = 0, retB = 0, winCntA = 0, winCntB = 0;
  int stabErr = 0, pcErr = 0, updErr = 0, predWait = 0, maxWait = 0;
  logic [WW-1:0] winLogA [0:3];
  logic [WW-1:0] winLogB [0:3];
  logic          prevReqA = 1'b0;
  logic [AS-1:0] prevPCA = '0;

  // 1-cycle trace ROMs
  always @(posedge Clk) begin
    traceDataA <= rom[traceAddrA[2:0]];
    traceDataB <= rom[traceAddrB[2:0]];
  end

  assign predValidA = predReqA && (predWait >= predDelay);
  assign predTakenA = rom[brA[2:0]][AS] ^ wrongMask[brA[2:0]];
  assign updAckA    = updReqA && !updHold;
  assign predValidB = predReqB;
  assign predTakenB = rom[brB[2:0]][AS];
  assign updAckB    = updReqB;

  // Branch tracking, window log and handshake-stability monitors
  always @(posedge Clk) begin
    predWait <= (predReqA && !predValidA) ? predWait + 1 : 0;
    prevReqA <= predReqA;
    prevPCA  <= predPCA;
    if (startA) begin
      brA <= '0; retA <= 0; winCntA <= 0; stabErr <= 0; pcErr <= 0; updErr <= 0; maxWait <= 0;
    end else begin
      if (updReqA && updAckA) begin brA <= brA + 4'd1; retA <= retA + 1; end
      if (winValidA) begin winLogA[winCntA % 4] <= winHitsA; winCntA <= winCntA + 1; end
      if (predReqA && prevReqA && (predPCA != prevPCA)) stabErr <= stabErr + 1;
      if (predReqA && (predPCA != rom[brA[2:0]][AS-1:0])) pcErr <= pcErr + 1;
      if (updReqA && (updTakenA != rom[brA[2:0]][AS])) updErr <= updErr + 1;
      if (predWait > maxWait) maxWait <= predWait;
    end
    if (startB) begin
      brB <= '0; retB <= 0; winCntB <= 0;
    end else begin
      if (updReqB && updAckB) begin brB <= brB + 3'd1; retB <= retB + 1; end
      if (winValidB) begin winLogB[winCntB % 4] <= winHitsB; winCntB <= winCntB + 1; end
    end
  end

  task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmpCount++;
    if (obs !== exp) begin
      errCount++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulseStart(input logic a, input logic b);
    @(negedge Clk);
    startA = a; startB = b;
    @(negedge Clk);
    startA = 1'b0; startB = 1'b0;
  endtask

  task automatic waitDoneA(input int budget);
    int cyc = 0;
    while (!doneA && cyc < budget) begin @(negedge Clk); cyc++; end
    checkValue("doneA within budget", {63'd0, doneA}, 64'd1);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rom[i] = {outcomeBits[i], 32'h0000_1000 + 32'(4 * i)};

    // Reset held low with Start asserted
    startA = 1'b1;
    repeat (3) @(negedge Clk);
    checkValue("rst TraceAddr", 64'(traceAddrA), 64'd0);
    checkValue("rst PredReq", 64'(predReqA), 64'd0);
    checkValue("rst PredPC", 64'(predPCA), 64'd0);
    checkValue("rst UpdReq", 64'(updReqA), 64'd0);
    checkValue("rst UpdTaken", 64'(updTakenA), 64'd0);
    checkValue("rst Totals", 64'({totalA, correctA}), 64'd0);
    checkValue("rst Window", 64'({winHitsA, winValidA}), 64'd0);
    checkValue("rst Busy/Done", 64'({busyA, doneA}), 64'd0);
    startA = 1'b0;
    Rst = 1'b1;
    @(negedge Clk);
    checkValue("idle after reset Busy", 64'(busyA), 64'd0);

    // Zero-wait, all predictions correct: Done exactly 32 cycles after Start
    pulseStart(1'b1, 1'b0);
    repeat (31) @(negedge Clk);
    checkValue("run1 Busy mid", 64'(busyA), 64'd1);
    checkValue("run1 Done not early", 64'(doneA), 64'd0);
    @(negedge Clk);
    checkValue("run1 Done at 32", 64'(doneA), 64'd1);
    checkValue("run1 Busy end", 64'(busyA), 64'd0);
    checkValue("run1 Total", 64'(totalA), 64'd8);
    checkValue("run1 Correct", 64'(correctA), 64'd8);
    checkValue("run1 retires", 64'(retA), 64'd8);
    checkValue("run1 PredPC errs", 64'(pcErr), 64'd0);
    checkValue("run1 UpdTaken errs", 64'(updErr), 64'd0);
`ifdef TRACE_WINDOW_STATS_EN
    checkValue("run1 window pulses", 64'(winCntA), 64'd2);
    checkValue("run1 window0", 64'(winLogA[0]), 64'd4);
    checkValue("run1 window1", 64'(winLogA[1]), 64'd4);
`else
    checkValue("run1 window pulses", 64'(winCntA), 64'd0);
`endif

    // Wrong predictions on entries 1 and 5
    wrongMask = 8'b0010_0010;
    pulseStart(1'b1, 1'b0);
    waitDoneA(100);
    checkValue("run2 Total", 64'(totalA), 64'd8);
    checkValue("run2 Correct", 64'(correctA), 64'd6);
`ifdef TRACE_WINDOW_STATS_EN
    checkValue("run2 window pulses", 64'(winCntA), 64'd2);
    checkValue("run2 window0", 64'(winLogA[0]), 64'd3);
    checkValue("run2 window1", 64'(winLogA[1]), 64'd3);
    checkValue("run2 WindowHits held", 64'(winHitsA), 64'd3);
`else
    checkValue("run2 window pulses", 64'(winCntA), 64'd0);
    checkValue("run2 WindowHits tied", 64'(winHitsA), 64'd0);
`endif

    // PredValid delayed 5 cycles
    wrongMask = 8'd0;
    predDelay = 5;
    pulseStart(1'b1, 1'b0);
    waitDoneA(300);
    checkValue("run3 PredPC stable", 64'(stabErr), 64'd0);
    checkValue("run3 PredPC value", 64'(pcErr), 64'd0);
    checkValue("run3 max wait", 64'(maxWait), 64'd5);
    checkValue("run3 retires", 64'(retA), 64'd8);
    checkValue("run3 Total", 64'(totalA), 64'd8);
    checkValue("run3 Correct", 64'(correctA), 64'd8);
    predDelay = 0;

    // Six-entry trace: full window of 4 then partial window of 2
    pulseStart(1'b0, 1'b1);
    for (int c = 0; c < 100 && !doneB; c++) @(negedge Clk);
    checkValue("runB Done", 64'(doneB), 64'd1);
    checkValue("runB Total", 64'(totalB), 64'd6);
    checkValue("runB Correct", 64'(correctB), 64'd6);
    checkValue("runB retires", 64'(retB), 64'd6);
`ifdef TRACE_WINDOW_STATS_EN
    checkValue("runB window pulses", 64'(winCntB), 64'd2);
    checkValue("runB window0", 64'(winLogB[0]), 64'd4);
    checkValue("runB window1 partial", 64'(winLogB[1]), 64'd2);
`else
    checkValue("runB window pulses", 64'(winCntB), 64'd0);
`endif

    // Reset during UPDATE of entry 3, then restart
    pulseStart(1'b1, 1'b0);
    for (int c = 0; c < 100 && !(updReqA && brA == 4'd3); c++) @(negedge Clk);
    checkValue("mid UPDATE of entry 3", 64'({updReqA, brA}), 64'({1'b1, 4'd3}));
    checkValue("mid Total before reset", 64'(totalA), 64'd3);
    Rst = 1'b0;
    #1;
    checkValue("mid rst Totals", 64'({totalA, correctA}), 64'd0);
    checkValue("mid rst Reqs", 64'({predReqA, updReqA}), 64'd0);
    checkValue("mid rst Busy/Done", 64'({busyA, doneA}), 64'd0);
    checkValue("mid rst TraceAddr", 64'(traceAddrA), 64'd0);
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    checkValue("mid idle after release", 64'({busyA, updReqA}), 64'd0);
    pulseStart(1'b1, 1'b0);
    checkValue("restart TraceAddr", 64'(traceAddrA), 64'd0);
    checkValue("restart Busy", 64'(busyA), 64'd1);
    waitDoneA(100);
    checkValue("restart Total", 64'(totalA), 64'd8);
    checkValue("restart PredPC errs", 64'(pcErr), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule
